// File: rtl/wrr_pkg.sv
// Shared definitions for the weighted round-robin VC scheduler.
package wrr_pkg;

    localparam int NUM_VC  = 4;
    localparam int VC_ID_W = 2;

    typedef enum logic {
        IDLE,
        SERVE
    } state_e;

    function automatic logic [NUM_VC-1:0] onehot(input logic [VC_ID_W-1:0] id);
        logic [NUM_VC-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wrr_rr_pick.sv
// Rotating-priority picker: first eligible VC at or after ptr, wrapping mod NUM_VC.
module wrr_rr_pick
    import wrr_pkg::*;
(
    input  logic [NUM_VC-1:0]  eligible,
    input  logic [VC_ID_W-1:0] ptr,
    output logic               found,
    output logic [VC_ID_W-1:0] idx
);

    logic [VC_ID_W-1:0] cand;

    // Scan from the farthest offset down so the closest eligible VC to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            cand = ptr + VC_ID_W'(k);
            if (eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wrr_vc_scheduler.sv
// Weighted round-robin scheduler choosing which VC drives the shared output mux.
module wrr_vc_scheduler
    import wrr_pkg::*;
#(
    parameter int WEIGHT_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_VC-1:0]          req,
    input  logic [NUM_VC*WEIGHT_W-1:0] weight,
    input  logic                       ready,
    output logic                       grant_valid,
    output logic [VC_ID_W-1:0]         vc_id,
    output logic [NUM_VC-1:0]          grant,
    output logic [NUM_VC-1:0]          pop
);

    state_e              state_q, state_d;
    logic                grant_valid_q, grant_valid_d;
    logic [VC_ID_W-1:0]  vc_id_q, vc_id_d;
    logic [VC_ID_W-1:0]  ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;

    logic [WEIGHT_W-1:0] weight_arr [NUM_VC];
    logic [NUM_VC-1:0]   eligible;
    logic [VC_ID_W-1:0]  pick_ptr;
    logic [VC_ID_W-1:0]  pick_idx;
    logic                pick_found;
    logic [WEIGHT_W-1:0] credit_dec;
    logic                transfer;
    logic                withdraw;

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            weight_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
            eligible[i]   = req[i] && (weight_arr[i] != '0);
        end
    end

    // While serving, any re-pick starts just past the current VC.
    assign pick_ptr = (state_q == SERVE) ? vc_id_q + VC_ID_W'(1) : ptr_q;

    wrr_rr_pick u_pick (
        .eligible (eligible),
        .ptr      (pick_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    assign transfer   = (state_q == SERVE) && ready;
    assign withdraw   = (state_q == SERVE) && !ready && !req[vc_id_q];
    assign credit_dec = credit_q - WEIGHT_W'(1);

    always_comb begin
        state_d  = state_q;
        vc_id_d  = vc_id_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = SERVE;
                    vc_id_d  = pick_idx;
                    credit_d = weight_arr[pick_idx];
                end
            end
            SERVE: begin
                if (transfer && (credit_dec != '0) && req[vc_id_q]) begin
                    credit_d = credit_dec;
                end else if (transfer || withdraw) begin
                    // End of turn: leftover credit is forfeited, the winner gets a fresh load.
                    ptr_d = vc_id_q + VC_ID_W'(1);
                    if (pick_found) begin
                        vc_id_d  = pick_idx;
                        credit_d = weight_arr[pick_idx];
                    end else begin
                        state_d  = IDLE;
                        credit_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        grant_valid_d = (state_d == SERVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            vc_id_q       <= '0;
            ptr_q         <= '0;
            credit_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            vc_id_q       <= vc_id_d;
            ptr_q         <= ptr_d;
            credit_q      <= credit_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign vc_id       = vc_id_q;
    assign grant       = grant_valid_q ? onehot(vc_id_q) : '0;
    assign pop         = grant & {NUM_VC{ready}};

endmodule
